// File: rtl/radar_scan_sequencer.sv
// Servo sweep sequencer: step, settle, trigger one telemeter measurement, then
// emit an (angle, distance) sample on a valid/ready stream, bouncing between limits.
module radar_scan_sequencer #(
    parameter int POS_W          = 8,
    parameter int DIST_W         = 10,
    parameter int POS_MIN        = 0,
    parameter int POS_MAX        = 180,
    parameter int POS_STEP       = 10,
    parameter int SETTLE_CYCLES  = 5000000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [POS_W-1:0]  servo_pos,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_dist,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [POS_W-1:0]  sample_angle,
    output logic [DIST_W-1:0] sample_dist,
    output logic              sample_timeout,
    output logic              busy,
    output logic              sweep_dir
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PW1     = POS_W + 1;
    localparam int PWS     = POS_W + 2;

    localparam logic [CNT_W-1:0]        SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);
    localparam logic [POS_W-1:0]        POS_RESET    = POS_W'(POS_MIN);
    localparam logic [POS_W:0]          STEP_X       = PW1'(POS_STEP);
    localparam logic [POS_W:0]          MAX_X        = PW1'(POS_MAX);
    localparam logic signed [POS_W+1:0] STEP_S       = PWS'(POS_STEP);
    localparam logic signed [POS_W+1:0] MIN_S        = PWS'(POS_MIN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TRIG   = 3'd2,
        WAIT   = 3'd3,
        EMIT   = 3'd4
    } state_t;

    // Returns {new_dir, new_pos}. Sums are widened so a limit overshoot is
    // detected instead of wrapping; the lower bound uses a signed compare.
    function automatic logic [POS_W:0] step_next(input logic [POS_W-1:0] pos,
                                                 input logic             dir);
        logic [POS_W:0]          up;
        logic signed [POS_W+1:0] dn;
        up = {1'b0, pos} + STEP_X;
        dn = $signed({2'b00, pos}) - STEP_S;
        if (!dir) begin
            if (up <= MAX_X) begin
                step_next = {1'b0, up[POS_W-1:0]};
            end else begin
                step_next = {1'b1, dn[POS_W-1:0]};
            end
        end else begin
            if (dn >= MIN_S) begin
                step_next = {1'b1, dn[POS_W-1:0]};
            end else begin
                step_next = {1'b0, up[POS_W-1:0]};
            end
        end
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [POS_W-1:0]    pos_r, pos_s;
    logic                dir_r, dir_s;
    logic                start_r, start_s;
    logic                valid_r, valid_s;
    logic [POS_W-1:0]    angle_r, angle_s;
    logic [DIST_W-1:0]   dist_r, dist_s;
    logic                timeout_r, timeout_s;
    logic                busy_r, busy_s;
    logic [POS_W:0]      step_s;

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pos_s     = pos_r;
        dir_s     = dir_r;
        start_s   = 1'b0;
        valid_s   = valid_r;
        angle_s   = angle_r;
        dist_s    = dist_r;
        timeout_s = timeout_r;
        step_s    = step_next(pos_r, dir_r);

        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = SETTLE;
                    cnt_s   = SETTLE_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                // meas_start is registered, so it is raised on entry to TRIG
                if (cnt_r == CNT_ZERO) begin
                    state_s = TRIG;
                    start_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            TRIG: begin
                state_s = WAIT;
                cnt_s   = TIMEOUT_LOAD;
            end
            WAIT: begin
                if (meas_done) begin
                    state_s   = EMIT;
                    valid_s   = 1'b1;
                    angle_s   = pos_r;
                    dist_s    = meas_dist;
                    timeout_s = 1'b0;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s   = EMIT;
                    valid_s   = 1'b1;
                    angle_s   = pos_r;
                    dist_s    = {DIST_W{1'b1}};
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            EMIT: begin
                // Servo only moves once the consumer has taken the sample
                if (sample_ready) begin
                    valid_s = 1'b0;
                    pos_s   = step_s[POS_W-1:0];
                    dir_s   = step_s[POS_W];
                    if (enable) begin
                        state_s = SETTLE;
                        cnt_s   = SETTLE_LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            pos_r     <= POS_RESET;
            dir_r     <= 1'b0;
            start_r   <= 1'b0;
            valid_r   <= 1'b0;
            angle_r   <= {POS_W{1'b0}};
            dist_r    <= {DIST_W{1'b0}};
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pos_r     <= pos_s;
            dir_r     <= dir_s;
            start_r   <= start_s;
            valid_r   <= valid_s;
            angle_r   <= angle_s;
            dist_r    <= dist_s;
            timeout_r <= timeout_s;
            busy_r    <= busy_s;
        end
    end

    assign servo_pos      = pos_r;
    assign sweep_dir      = dir_r;
    assign meas_start     = start_r;
    assign sample_valid   = valid_r;
    assign sample_angle   = angle_r;
    assign sample_dist    = dist_r;
    assign sample_timeout = timeout_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_radar_scan_sequencer.sv
// Self-checking bench for radar_scan_sequencer: directed scenarios with literal
// expectations plus a randomized run checked every cycle against an event-timeline model.
module tb_radar_scan_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 8;
    localparam int PMIN    = 0;
    localparam int PMAX    = 30;
    localparam int STEP    = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       meas_done;
    logic [9:0] meas_dist;
    logic       sample_ready = 1'b1;
    logic [7:0] servo_pos;
    logic       meas_start;
    logic       sample_valid;
    logic [7:0] sample_angle;
    logic [9:0] sample_dist;
    logic       sample_timeout;
    logic       busy;
    logic       sweep_dir;

    radar_scan_sequencer #(
        .POS_W(8), .DIST_W(10), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_STEP(STEP),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .servo_pos(servo_pos), .meas_start(meas_start),
        .meas_done(meas_done), .meas_dist(meas_dist),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_angle(sample_angle), .sample_dist(sample_dist),
        .sample_timeout(sample_timeout), .busy(busy), .sweep_dir(sweep_dir)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int start_count = 0;
    int hs_count = 0;

    int resp_mode = 1;
    int resp_d = 2;
    logic [9:0] resp_dist = 10'h123;

    int exp_ang [0:6] = '{10, 20, 30, 20, 10, 0, 10};
    int exp_dir [0:6] = '{0, 0, 1, 1, 1, 0, 0};

    // Timeline model: each step is described by the cycle of its trigger and
    // the last cycle in which a measurement may still arrive.
    int m_pos, m_trig, m_deadline, m_angle, m_dist;
    bit m_dir, m_busy, m_wait, m_valid, m_to;

    function automatic int model_next_pos(int p, bit d);
        if (!d) return (p + STEP <= PMAX) ? p + STEP : p - STEP;
        return (p - STEP >= PMIN) ? p - STEP : p + STEP;
    endfunction

    function automatic bit model_next_dir(int p, bit d);
        if (!d) return (p + STEP > PMAX);
        return (p - STEP >= PMIN);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos <= PMIN; m_dir <= 1'b0; m_busy <= 1'b0; m_wait <= 1'b0;
            m_trig <= -1; m_deadline <= 0; m_valid <= 1'b0;
            m_angle <= 0; m_dist <= 0; m_to <= 1'b0;
        end else if (!m_busy) begin
            if (enable) begin
                m_busy <= 1'b1;
                m_trig <= cyc + SETTLE + 1;
            end
        end else if (m_trig == cyc) begin
            m_trig <= -1;
            m_wait <= 1'b1;
            m_deadline <= cyc + TIMEOUT;
        end else if (m_wait) begin
            if (meas_done) begin
                m_wait <= 1'b0; m_valid <= 1'b1; m_angle <= m_pos;
                m_dist <= int'(meas_dist); m_to <= 1'b0;
            end else if (cyc == m_deadline) begin
                m_wait <= 1'b0; m_valid <= 1'b1; m_angle <= m_pos;
                m_dist <= 1023; m_to <= 1'b1;
            end
        end else if (m_valid && sample_ready) begin
            m_valid <= 1'b0;
            m_pos <= model_next_pos(m_pos, m_dir);
            m_dir <= model_next_dir(m_pos, m_dir);
            if (enable) m_trig <= cyc + SETTLE + 1;
            else m_busy <= 1'b0;
        end
    end

    // Telemeter stand-in: answers each trigger after a chosen delay.
    initial begin
        int resp_cnt;
        int d;
        logic [9:0] rdist;
        meas_done = 1'b0;
        meas_dist = 10'h000;
        resp_cnt = -1;
        rdist = 10'h000;
        forever begin
            @(posedge clk); #1;
            meas_done = 1'b0;
            if (resp_cnt == 0) begin
                meas_done = 1'b1;
                meas_dist = rdist;
            end
            if (resp_cnt >= 0) resp_cnt = resp_cnt - 1;
            if (meas_start && resp_mode != 0) begin
                if (resp_mode == 1) begin
                    d = resp_d;
                    rdist = resp_dist;
                end else begin
                    d = $urandom_range(0, 10);
                    rdist = 10'($urandom_range(0, 1023));
                end
                if (d == 0) begin
                    meas_done = 1'b1;
                    meas_dist = rdist;
                end else begin
                    resp_cnt = d - 1;
                end
            end else if (resp_mode == 2 && resp_cnt < 0 && $urandom_range(0, 31) == 0) begin
                meas_done = 1'b1;
                meas_dist = 10'($urandom_range(0, 1023));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            check("servo_pos", 32'(servo_pos), m_pos);
            check("sweep_dir", 32'(sweep_dir), 32'(m_dir));
            check("meas_start", 32'(meas_start), (m_busy && m_trig == cyc) ? 32'd1 : 32'd0);
            check("busy", 32'(busy), 32'(m_busy));
            check("sample_valid", 32'(sample_valid), 32'(m_valid));
            check("sample_angle", 32'(sample_angle), m_angle);
            check("sample_dist", 32'(sample_dist), m_dist);
            check("sample_timeout", 32'(sample_timeout), 32'(m_to));
            if (meas_start === 1'b1) start_count++;
            if (sample_valid === 1'b1 && sample_ready === 1'b1) hs_count++;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_start(input string tag, output int c);
        c = -1;
        for (int i = 0; i < 200 && meas_start !== 1'b1; i++) tick();
        if (meas_start === 1'b1) c = cyc;
        else check({tag, "_start_bound"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag, output int c);
        c = -1;
        for (int i = 0; i < 200 && sample_valid !== 1'b1; i++) tick();
        if (sample_valid === 1'b1) c = cyc;
        else check({tag, "_valid_bound"}, 32'd0, 32'd1);
    endtask

    initial begin
        int e, t, v, t2, v2, s0, h0;
        logic [7:0] a0, p0;
        logic [9:0] d0;
        logic o0;
        bit stable;
        fork
            cmp_loop();
        join_none

        // Reset state and basic step
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("t0_servo_pos", 32'(servo_pos), 32'd0);
        check("t0_busy", 32'(busy), 32'd0);
        check("t0_valid", 32'(sample_valid), 32'd0);
        resp_mode = 1; resp_d = 2; resp_dist = 10'h123;
        s0 = start_count;
        enable = 1'b1;
        e = cyc;
        wait_start("t1", t);
        check("t1_start_latency", t - e, 32'd5);
        wait_valid("t1", v);
        check("t1_valid_latency", v - t, 32'd3);
        check("t1_angle", 32'(sample_angle), 32'd0);
        check("t1_dist", 32'(sample_dist), 32'h123);
        check("t1_timeout", 32'(sample_timeout), 32'd0);
        tick();
        check("t1_pos_after", 32'(servo_pos), 32'd10);
        check("t1_start_pulses", start_count - s0, 32'd1);

        // Bounce between the limits
        for (int k = 0; k < 7; k++) begin
            wait_valid("t2", v);
            check("t2_angle", 32'(sample_angle), exp_ang[k]);
            tick();
            check("t2_dir", 32'(sweep_dir), exp_dir[k]);
        end

        // Timeout, then measurement arriving on the last waiting cycle
        do_reset();
        resp_mode = 0;
        enable = 1'b1;
        wait_start("t3", t);
        wait_valid("t3", v);
        check("t3_timeout_latency", v - t, 32'd9);
        check("t3_to_dist", 32'(sample_dist), 32'h3FF);
        check("t3_to_flag", 32'(sample_timeout), 32'd1);
        resp_mode = 1; resp_d = 8; resp_dist = 10'h055;
        wait_start("t3b", t2);
        wait_valid("t3b", v2);
        check("t3_tie_latency", v2 - t2, 32'd9);
        check("t3_tie_dist", 32'(sample_dist), 32'h055);
        check("t3_tie_flag", 32'(sample_timeout), 32'd0);
        check("t3_tie_angle", 32'(sample_angle), 32'd10);

        // Backpressure on the pending sample
        sample_ready = 1'b0;
        a0 = sample_angle; d0 = sample_dist; o0 = sample_timeout; p0 = servo_pos;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sample_valid !== 1'b1 || sample_angle !== a0 || sample_dist !== d0 ||
                sample_timeout !== o0 || servo_pos !== p0 || meas_start !== 1'b0)
                stable = 1'b0;
        end
        check("t4_stall_stable", 32'(stable), 32'd1);
        enable = 1'b0;
        h0 = hs_count;
        sample_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t4_one_transfer", hs_count - h0, 32'd1);
        check("t4_pos", 32'(servo_pos), 32'd20);
        check("t4_busy", 32'(busy), 32'd0);

        // Disable during settle, then resume
        do_reset();
        resp_mode = 1; resp_d = 1; resp_dist = 10'h100;
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid("t5", v);
            tick();
        end
        enable = 1'b0;
        wait_valid("t5b", v);
        check("t5_angle_20", 32'(sample_angle), 32'd20);
        for (int i = 0; i < 4; i++) tick();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_pos", 32'(servo_pos), 32'd30);
        enable = 1'b1;
        wait_valid("t5c", v);
        check("t5_resume_angle", 32'(sample_angle), 32'd30);

        // Asynchronous reset while waiting for a measurement
        resp_d = 5;
        tick();
        wait_start("t6", t);
        tick();
        tick();
        #2;
        reset = 1'b1;
        enable = 1'b0;
        #1;
        check("t6_pos", 32'(servo_pos), 32'd0);
        check("t6_dir", 32'(sweep_dir), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(sample_valid), 32'd0);
        check("t6_fields", {sample_angle, sample_dist, sample_timeout, meas_start}, 32'd0);
        tick();
        reset = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sample_valid !== 1'b0) stable = 1'b0;
        end
        check("t6_no_late_sample", 32'(stable), 32'd1);

        // Randomized run against the model
        do_reset();
        resp_mode = 2;
        enable = 1'b1;
        h0 = hs_count;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            sample_ready = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin
                #2;
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        check("rand_progress", (hs_count - h0 > 20) ? 32'd1 : 32'd0, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
